// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-side burst engine for a registered-output RAM port
// with one cycle of read latency. When start is accepted it streams `length`
// consecutive words, beginning at base_addr, onto a valid/ready output
// stream. The read address wraps modulo 2**widthad.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   start                begin a burst (ignored while busy)
//   base_addr, length    burst start address and word count (0..2**widthad)
//   busy, done           burst in progress / one-cycle completion pulse
//   ram_address, ram_wren, ram_q   RAM read port (ram_wren tied low)
//   out_data, out_valid, out_ready, out_last   output stream
module ram_burst_reader #(
  parameter int width   = 8,
  parameter int widthad = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [widthad-1:0] base_addr,
  input  logic [widthad:0]   length,
  output logic               busy,
  output logic               done,
  output logic [widthad-1:0] ram_address,
  output logic               ram_wren,
  input  logic [width-1:0]   ram_q,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [widthad:0] CNT_ONE = (widthad+1)'(1);

  state_t             state;
  logic [widthad:0]   issue_cnt;   // reads still to be issued
  logic [widthad:0]   out_cnt;     // words still to be captured
  logic               pending;     // a read is in flight; ram_q is valid now

  // Two-entry output FIFO held as head/tail registers so the stream outputs
  // come straight from flops.
  logic               head_vld, tail_vld;
  logic               head_last, tail_last;
  logic [width-1:0]   head_data, tail_data;

  logic               pop, push, final_hs, issue, cap_last;
  logic [2:0]         occupancy;

  assign ram_wren  = 1'b0;
  assign out_data  = head_data;
  assign out_valid = head_vld;
  assign out_last  = head_last;

  assign pop      = head_vld & out_ready;
  assign push     = pending;
  assign final_hs = pop & head_last;
  assign cap_last = (out_cnt == CNT_ONE);

  // Words that will occupy the FIFO after this edge if nothing new is issued;
  // a new read may only go out when it is guaranteed a free slot.
  assign occupancy = {2'b00, head_vld} + {2'b00, tail_vld} + {2'b00, pending}
                   - {2'b00, pop};
  assign issue = (state == READ) && (occupancy < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_address <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      pending     <= 1'b0;
      head_vld    <= 1'b0;
      tail_vld    <= 1'b0;
      head_last   <= 1'b0;
      tail_last   <= 1'b0;
      head_data   <= '0;
      tail_data   <= '0;
    end else begin
      done    <= 1'b0;
      pending <= issue;
      if (push) out_cnt <= out_cnt - CNT_ONE;

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              ram_address <= base_addr;
              issue_cnt   <= length;
              out_cnt     <= length;
              busy        <= 1'b1;
              state       <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            ram_address <= ram_address + widthad'(1);
            issue_cnt   <= issue_cnt - CNT_ONE;
            if (issue_cnt == CNT_ONE) state <= DRAIN;
          end
        end
        default: ;
      endcase

      if (final_hs) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end

      case ({push, pop})
        2'b10: begin
          if (!head_vld) begin
            head_data <= ram_q;
            head_last <= cap_last;
            head_vld  <= 1'b1;
          end else begin
            tail_data <= ram_q;
            tail_last <= cap_last;
            tail_vld  <= 1'b1;
          end
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          head_vld  <= tail_vld;
          tail_vld  <= 1'b0;
        end
        2'b11: begin
          if (tail_vld) begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= ram_q;
            tail_last <= cap_last;
          end else begin
            head_data <= ram_q;
            head_last <= cap_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader (widthad=4, RAM[i]=0xA0+i). A queue model of
// the expected word stream plus busy/done expectations is checked every
// cycle; directed per-cycle recordings pin latency and boundary cases.
module tb_ram_burst_reader;

  logic       clock = 1'b0;
  logic       reset, start, busy, done, ram_wren, out_valid, out_ready, out_last;
  logic [3:0] base_addr, ram_address;
  logic [4:0] length;
  logic [7:0] ram_q, out_data;
  logic [7:0] mem [16];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  ram_burst_reader #(.width(8), .widthad(4)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ram_address(ram_address),
    .ram_wren(ram_wren), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always @(posedge clock) ram_q <= mem[ram_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [7:0] d; logic l; } ent_t;
  ent_t q[$];
  logic m_busy = 1'b0, m_done = 1'b0;
  logic p_stall = 1'b0, p_rst = 1'b1;
  logic [7:0] p_data = '0;

  always @(negedge clock) begin
    ent_t e;
    logic n_busy, n_done;
    if (chk_en) begin
      chk("ram_wren", ram_wren, 1'b0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
      else if (out_valid) begin
        chk("stream_data", out_data, q[0].d);
        chk("stream_last", out_last, q[0].l);
      end
      if (p_stall && !p_rst) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, p_data);
      end
    end
    if (reset) begin
      q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      n_busy = m_busy;
      n_done = 1'b0;
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        if (e.l) begin n_busy = 1'b0; n_done = 1'b1; end
      end
      if (!m_busy && start) begin
        if (length == 0) n_done = 1'b1;
        else begin
          n_busy = 1'b1;
          for (int i = 0; i < int'(length); i++) begin
            e.d = mem[(int'(base_addr) + i) % 16];
            e.l = (i == int'(length) - 1);
            q.push_back(e);
          end
        end
      end
      m_busy = n_busy;
      m_done = n_done;
    end
    p_stall = out_valid && !out_ready;
    p_data  = out_data;
    p_rst   = reset;
  end

  // ---------------- directed stimulus ----------------
  logic       rv [64], rl [64], rdn [64], rb [64], rr [64];
  logic [7:0] rd [64];
  logic [3:0] ra [64];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 carries the start; per-cycle samples land in the r* arrays.
  task automatic burst(input int b, input int l, input int ncyc, input logic [63:0] rdy,
                       input int xs1, input int xb1, input int xl1,
                       input int xs2, input int xb2, input int xl2, input int rst_c);
    step();
    start = 1'b1; base_addr = 4'(b); length = 5'(l); out_ready = rdy[0];
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      rv[c] = out_valid; rd[c] = out_data; rl[c] = out_last;
      rdn[c] = done; rb[c] = busy; ra[c] = ram_address; rr[c] = out_ready;
      step();
      if (c + 1 == xs1) begin start = 1'b1; base_addr = 4'(xb1); length = 5'(xl1); end
      else if (c + 1 == xs2) begin start = 1'b1; base_addr = 4'(xb2); length = 5'(xl2); end
      else start = 1'b0;
      reset = (c + 1 == rst_c);
      out_ready = rdy[c + 1];
    end
    start = 1'b0; reset = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] all1, tog, rst_rdy;
    logic [5:0]  pat;
    int hs, nd;
    all1 = '1;
    pat  = 6'b101001;  // cycle c ready = pat[c % 6]: 1,0,0,1,0,1
    for (int i = 0; i < 64; i++) tog[i] = pat[i % 6];
    rst_rdy = all1;
    rst_rdy[5] = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;

    step();
    chk_en = 1;
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);      chk("rst_done", done, 1'b0);
    chk("rst_addr", ram_address, 4'd0); chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);  chk("rst_data", out_data, 8'h00);
    step();
    reset = 1'b0;
    step();

    // basic: base 2, len 4
    burst(2, 4, 9, all1, -1, 0, 0, -1, 0, 0, -1);
    chk("t1_addr_c1", ra[1], 4'd2);  chk("t1_busy_c1", rb[1], 1'b1);
    chk("t1_valid_c2", rv[2], 1'b0);
    for (int c = 3; c <= 6; c++) begin
      chk("t1_valid", rv[c], 1'b1);
      chk("t1_data", rd[c], 8'(8'hA2 + c - 3));
    end
    chk("t1_last_c5", rl[5], 1'b0);  chk("t1_last_c6", rl[6], 1'b1);
    chk("t1_done_c6", rdn[6], 1'b0); chk("t1_done_c7", rdn[7], 1'b1);
    chk("t1_busy_c7", rb[7], 1'b0);  chk("t1_done_c8", rdn[8], 1'b0);

    // wrap across top of address space
    burst(14, 4, 9, all1, -1, 0, 0, -1, 0, 0, -1);
    chk("t2_addr_c1", ra[1], 4'd14); chk("t2_addr_c2", ra[2], 4'd15);
    chk("t2_addr_c3", ra[3], 4'd0);  chk("t2_addr_c4", ra[4], 4'd1);
    chk("t2_data_c3", rd[3], 8'hAE); chk("t2_data_c5", rd[5], 8'hA0);
    chk("t2_data_c6", rd[6], 8'hA1); chk("t2_last_c6", rl[6], 1'b1);

    // full RAM, len = 16
    burst(3, 16, 21, all1, -1, 0, 0, -1, 0, 0, -1);
    chk("t3_data_first", rd[3], 8'hA3); chk("t3_addr_c16", ra[16], 4'd2);
    chk("t3_data_end", rd[18], 8'hA2);  chk("t3_last_c17", rl[17], 1'b0);
    chk("t3_last_c18", rl[18], 1'b1);   chk("t3_done_c19", rdn[19], 1'b1);

    // back-pressure
    burst(6, 4, 30, tog, -1, 0, 0, -1, 0, 0, -1);
    hs = 0; nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (rv[c] && rr[c]) hs++;
      if (rdn[c]) nd++;
    end
    chk("t4_handshakes", 32'(hs), 32'd4);
    chk("t4_done_count", 32'(nd), 32'd1);

    // zero length
    burst(7, 0, 4, all1, -1, 0, 0, -1, 0, 0, -1);
    chk("t5_done_c1", rdn[1], 1'b1); chk("t5_busy_c1", rb[1], 1'b0);
    chk("t5_done_c2", rdn[2], 1'b0);
    for (int c = 0; c < 4; c++) chk("t5_no_valid", rv[c], 1'b0);

    // start ignored mid-burst, restart in done cycle
    burst(0, 4, 16, all1, 2, 8, 3, 7, 9, 3, -1);
    chk("t6_addr_c2", ra[2], 4'd1);  chk("t6_data_c6", rd[6], 8'hA3);
    chk("t6_done_c7", rdn[7], 1'b1); chk("t6_busy_c8", rb[8], 1'b1);
    chk("t6_addr_c8", ra[8], 4'd9);  chk("t6_valid_c9", rv[9], 1'b0);
    chk("t6_data_c10", rd[10], 8'hA9); chk("t6_data_c12", rd[12], 8'hAB);
    chk("t6_last_c12", rl[12], 1'b1); chk("t6_done_c13", rdn[13], 1'b1);

    // reset mid-burst after two pops
    burst(0, 8, 8, rst_rdy, -1, 0, 0, -1, 0, 0, 5);
    chk("t7_pop1", rd[3], 8'hA0);    chk("t7_pop2", rd[4], 8'hA1);
    chk("t7_busy", rb[6], 1'b0);     chk("t7_done", rdn[6], 1'b0);
    chk("t7_addr", ra[6], 4'd0);     chk("t7_valid", rv[6], 1'b0);
    chk("t7_last", rl[6], 1'b0);     chk("t7_data", rd[6], 8'h00);
    chk("t7_done_c7", rdn[7], 1'b0);
    burst(5, 2, 7, all1, -1, 0, 0, -1, 0, 0, -1);
    chk("t7b_data_c3", rd[3], 8'hA5); chk("t7b_data_c4", rd[4], 8'hA6);
    chk("t7b_done_c5", rdn[5], 1'b1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
